ticket_dispense_sched: RTL and testbench
========================================

// Module: ticket_dispense_sched
// PURPOSE
//  Shares the single ticket dispenser among NREQ fare channels. Accepts one job (N tickets) at a
//  time by round-robin, then sequences the dispenser one ticket at a time: start pulse, wait for
//  its completion pulse, repeat. Reports job completion to the owning channel.
//  Sits between the fare/payment channels and the ticket-out unit (disp_start->its ready input).
// PARAMETERS
//  NREQ        4     number of requesting fare channels (>=2)
//  CNT_W       4     width of per-job ticket count
//  TMO_CYCLES  1000  cycles in WAIT before jam declared (JAM_TIMEOUT_EN only)
//  TMO_W       16    timeout counter width; TMO_CYCLES < 2**TMO_W
// PORTS
//  clk         in   1            clock
//  rst         in   1            reset, asynchronous, active-high
//  req_valid   in   NREQ         channel i has a job pending; held until req_ready[i]
//  req_count   in   NREQ*CNT_W   tickets requested; slice i = [i*CNT_W +: CNT_W]
//  req_ready   out  NREQ         one-cycle accept pulse, one-hot
//  done_pulse  out  NREQ         one-cycle job-finished pulse to owning channel, one-hot
//  done_abort  out  1            qualifies done_pulse: job aborted by jam
//  grant_id    out  $clog2(NREQ) owner of current job; valid while busy
//  busy        out  1            job in progress (grant to done inclusive)
//  disp_start  out  1            one-cycle "dispense one ticket" pulse to dispenser
//  disp_cmp    in   1            dispenser completion pulse (one cycle)
//  jam         out  1            dispenser timed out; held until jam_clr
//  jam_clr     in   1            operator clear of jam
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, remaining/timeout counters 0. Reset mid-job
//   drops the job silently (no done_pulse); dispenser shares rst.
//  All outputs registered. FSM: IDLE, ISSUE, WAIT, GAP, DONE, JAM.
//  IDLE: if any req_valid at edge N -> pick first valid at/after rr pointer; latch count and id.
//   Cycle N+1: req_ready[id]=1, busy=1, grant_id=id. count==0 -> DONE, else ISSUE.
//  ISSUE: disp_start=1 for exactly one cycle -> WAIT; timeout counter cleared.
//  WAIT: disp_cmp=1 -> remaining-1; remaining reaches 0 -> DONE, else GAP.
//   disp_cmp sampled only in WAIT; ignored in every other state.
//  GAP: one idle cycle (dispenser returns to idle) -> ISSUE. Start-to-start spacing >= 3 cycles.
//  DONE: done_pulse[id]=1 one cycle, done_abort as recorded; busy falls same cycle;
//   rr pointer <- id+1 mod NREQ (winner lowest priority next); -> IDLE. Next grant earliest 1 cycle later.
//  req_valid/req_count changes after accept do not affect the latched job.
//  Never two jobs in flight; disp_start never asserted outside ISSUE.
//  req_count is unsigned; decrement never wraps (exit at 0).
// CONFIGURATION
//  JAM_TIMEOUT_EN defined: WAIT counts cycles; reaching TMO_CYCLES without disp_cmp -> JAM:
//   jam=1, busy stays 1, no disp_start. jam_clr -> DONE with done_abort=1, jam=0.
//   disp_cmp on the same cycle as timeout: cmp wins, no jam. jam_clr outside JAM ignored.
//  Not defined: WAIT waits indefinitely; jam and done_abort tied 0; jam_clr unused; no counter.
// STRUCTURE
//  Shared package ticket_pkg: FSM state localparams (3-bit), default TMO_CYCLES, CNT_W.
//  Sub-module rr_arbiter (NREQ): req vector + pointer -> one-hot grant + index, combinational.
//  Top holds FSM, remaining counter, timeout counter, output registers.
// TESTING
//  1 Reset: assert rst mid-WAIT with count=3 -> all outputs 0 async, no done_pulse after release.
//  2 Single job: ch1 valid count=2, model cmp 4 cycles after start -> req_ready[1] next cycle,
//    exactly 2 disp_start pulses, >=1 GAP between, done_pulse[1] after 2nd cmp, done_abort=0.
//  3 Round-robin: ch0..ch3 all valid count=1 continuously -> grants 0,1,2,3,0; none starved.
//  4 count=0 on ch2 -> req_ready[2], done_pulse[2] next cycle, zero disp_start.
//  5 Spurious disp_cmp in IDLE/GAP -> ignored; remaining unchanged; ticket count still exact.
//  6 JAM_TIMEOUT_EN, TMO_CYCLES=20, no cmp -> jam=1 at 20 cycles after start; jam_clr ->
//    done_pulse with done_abort=1; cmp exactly at cycle 20 -> no jam. Without macro: jam stays 0.

Source files
------------

// File: rtl/ticket_dispense_sched_pkg.sv
// Shared types and defaults for the ticket dispenser scheduler.
// FSM state encoding plus default count width and jam timeout.
package ticket_pkg;

  localparam int DEF_CNT_W      = 4;
  localparam int DEF_TMO_CYCLES = 1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4,
    ST_JAM   = 3'd5
  } state_t;

endpackage

// File: rtl/ticket_dispense_sched_if.sv
// Channel/dispenser bundle for ticket_dispense_sched.
// master = fare channels + dispenser side, slave = scheduler.
interface ticket_dispense_sched_if
  import ticket_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = DEF_CNT_W
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*CNT_W-1:0]   req_count;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0]         done_pulse;
  logic                    done_abort;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic                    busy;
  logic                    disp_start;
  logic                    disp_cmp;
  logic                    jam;
  logic                    jam_clr;

  modport master (
    output req_valid, req_count, disp_cmp, jam_clr,
    input  req_ready, done_pulse, done_abort, grant_id,
    input  busy, disp_start, jam
  );

  modport slave (
    input  req_valid, req_count, disp_cmp, jam_clr,
    output req_ready, done_pulse, done_abort, grant_id,
    output busy, disp_start, jam
  );
endinterface

// File: rtl/ticket_dispense_sched_rr_arbiter.sv
// Combinational round-robin pick: first request at/after the pointer.
// Returns one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_any
);
  localparam int IDW = $clog2(NREQ);

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    // walk downwards so the lowest offset from the pointer wins
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % NREQ]) begin
        o_idx = IDW'((int'(i_ptr) + k) % NREQ);
        o_any = 1'b1;
      end
    end
    o_gnt = {{(NREQ-1){1'b0}}, o_any} << o_idx;
  end
endmodule

// File: rtl/ticket_dispense_sched.sv
// Round-robin job scheduler for the shared ticket dispenser.
// Define JAM_TIMEOUT_EN to enable the WAIT-state jam timeout.
module ticket_dispense_sched
  import ticket_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int TMO_CYCLES = DEF_TMO_CYCLES,
  parameter int TMO_W      = 16
) (
  input logic                    clk,
  input logic                    rst,
  ticket_dispense_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [CNT_W-1:0] r_rem;
  logic [NREQ-1:0]  r_req_ready;
  logic [NREQ-1:0]  r_done_pulse;
  logic             r_busy;
  logic             r_disp_start;

  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_idx;
  logic             w_any;
  logic [CNT_W-1:0] w_cnt;
  logic [IDW-1:0]   w_nxt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_cnt = bus.req_count[w_idx*CNT_W +: CNT_W];
  assign w_nxt = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);

`ifdef JAM_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo;
  logic             r_abort;
  logic             r_done_abort;
  logic             r_jam;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_id         <= '0;
      r_rem        <= '0;
      r_req_ready  <= '0;
      r_done_pulse <= '0;
      r_busy       <= 1'b0;
      r_disp_start <= 1'b0;
`ifdef JAM_TIMEOUT_EN
      r_tmo        <= '0;
      r_abort      <= 1'b0;
      r_done_abort <= 1'b0;
      r_jam        <= 1'b0;
`endif
    end else begin
      r_req_ready  <= '0;
      r_done_pulse <= '0;
      r_disp_start <= 1'b0;
`ifdef JAM_TIMEOUT_EN
      r_done_abort <= 1'b0;
`endif
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_id        <= w_idx;
            r_rem       <= w_cnt;
            r_req_ready <= w_gnt;
            r_busy      <= 1'b1;
`ifdef JAM_TIMEOUT_EN
            r_abort     <= 1'b0;
`endif
            r_state     <= (w_cnt == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_disp_start <= 1'b1;
`ifdef JAM_TIMEOUT_EN
          r_tmo        <= '0;
`endif
          r_state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // completion beats a timeout landing on the same edge
          if (bus.disp_cmp) begin
            r_rem   <= r_rem - CNT_W'(1);
            r_state <= (r_rem == CNT_W'(1)) ? ST_DONE : ST_GAP;
          end
`ifdef JAM_TIMEOUT_EN
          else if (r_tmo == TMO_W'(TMO_CYCLES - 1)) begin
            r_jam   <= 1'b1;
            r_state <= ST_JAM;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
`endif
        end
        ST_GAP: begin
          r_state <= ST_ISSUE;
        end
        ST_DONE: begin
          r_done_pulse <= {{(NREQ-1){1'b0}}, 1'b1} << r_id;
`ifdef JAM_TIMEOUT_EN
          r_done_abort <= r_abort;
`endif
          r_busy       <= 1'b0;
          r_ptr        <= w_nxt;
          r_state      <= ST_IDLE;
        end
        ST_JAM: begin
`ifdef JAM_TIMEOUT_EN
          if (bus.jam_clr) begin
            r_jam   <= 1'b0;
            r_abort <= 1'b1;
            r_state <= ST_DONE;
          end
`else
          r_state <= ST_IDLE;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.done_pulse = r_done_pulse;
  assign bus.grant_id   = r_id;
  assign bus.busy       = r_busy;
  assign bus.disp_start = r_disp_start;

`ifdef JAM_TIMEOUT_EN
  assign bus.done_abort = r_done_abort;
  assign bus.jam        = r_jam;
`else
  logic w_unused;
  assign w_unused       = bus.jam_clr;
  assign bus.done_abort = 1'b0;
  assign bus.jam        = 1'b0;
`endif
endmodule

// File: tb/tb_ticket_dispense_sched.sv
// Randomised self-checking bench for ticket_dispense_sched.
// Job-level round-robin model plus a behavioural dispenser.
module tb_ticket_dispense_sched;
  localparam int NREQ  = 4;
  localparam int CNT_W = 4;
  localparam int TMO   = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ticket_dispense_sched_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

  ticket_dispense_sched #(
    .NREQ(NREQ), .CNT_W(CNT_W), .TMO_CYCLES(TMO), .TMO_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0, cd = 0, dly = 0, m_ptr = 0, bad = 0;
  int cur_st = 0, last_st = -1, min_gap = 1000, tot_st = 0;
  int rdy_cyc = 0, st_cyc = -1, jam_cyc = -1, val_cyc = 0, jam_busy = 0;
  bit spur_now = 0, spur_gap = 0, auto_clr = 0, force_clr = 0;
  logic prev_jam = 1'b0;
  int o_rdy[$], o_done[$], o_ab[$], o_nst[$], o_lat[$], o_rlat[$];
  int exp_ord[$], exp_n[$], exp_a[$];

  function automatic longint pk(input int q[$]);
    longint r = longint'(q.size());
    foreach (q[i]) r = r * 16 + longint'(q[i] + 1);
    return r;
  endfunction

  // one cycle: observe outputs at negedge, act as channels and dispenser
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.disp_start) begin
      cur_st++; tot_st++;
      if (cur_st == 1) st_cyc = cyc;
      if (last_st >= 0 && cyc - last_st < min_gap) min_gap = cyc - last_st;
      last_st = cyc;
      if (!bus.busy) bad++;
    end
    if (bus.req_ready != '0) begin
      if (!$onehot(bus.req_ready)) bad++;
      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) begin
        o_rdy.push_back(i);
        o_rlat.push_back(cyc - val_cyc);
        bus.req_valid[i] = 1'b0;
        bus.req_count[i*CNT_W +: CNT_W] = CNT_W'($urandom);
      end
      cur_st = 0; last_st = -1; rdy_cyc = cyc;
    end
    if (bus.done_pulse != '0) begin
      if (!$onehot(bus.done_pulse)) bad++;
      for (int i = 0; i < NREQ; i++) if (bus.done_pulse[i]) begin
        o_done.push_back(i);
        o_ab.push_back(int'(bus.done_abort));
        o_nst.push_back(cur_st);
        o_lat.push_back(cyc - rdy_cyc);
      end
    end
    if (bus.busy && o_rdy.size() > 0 && int'(bus.grant_id) != o_rdy[$]) bad++;
    if (bus.jam && !prev_jam) begin
      jam_cyc = cyc; jam_busy = int'(bus.busy);
    end
    prev_jam = bus.jam;
    bus.disp_cmp = 1'b0;
    if (rst) begin
      cd = 0; spur_now = 0;
    end
    if (spur_now) begin
      bus.disp_cmp = 1'b1; spur_now = 0;
    end
    if (bus.disp_start) begin
      if (dly > 0) cd = dly;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.disp_cmp = 1'b1;
        if (spur_gap) spur_now = 1;
      end
    end
    bus.jam_clr = force_clr | (auto_clr & bus.jam);
  endtask

  // reference: round-robin order over a static pending set
  task automatic model_rr(input logic [NREQ-1:0] mask, input int cnt[NREQ]);
    logic [NREQ-1:0] m = mask;
    exp_ord.delete(); exp_n.delete(); exp_a.delete();
    while (m != '0) begin
      bit found = 0;
      for (int k = 0; k < NREQ; k++) begin
        int idx = (m_ptr + k) % NREQ;
        if (!found && m[idx]) begin
          found = 1;
          exp_ord.push_back(idx);
          exp_n.push_back(cnt[idx]);
          exp_a.push_back(0);
          m[idx] = 1'b0;
          m_ptr = (idx + 1) % NREQ;
        end
      end
    end
  endtask

  task automatic run_round(input logic [NREQ-1:0] mask, input int cnt[NREQ],
                           input int d, input bit sg, input int budget,
                           output bit tmo);
    int n = $countones(mask);
    o_rdy.delete(); o_done.delete(); o_ab.delete();
    o_nst.delete(); o_lat.delete(); o_rlat.delete();
    min_gap = 1000; jam_cyc = -1; st_cyc = -1;
    cur_st = 0; last_st = -1; dly = d; spur_gap = sg;
    for (int i = 0; i < NREQ; i++)
      bus.req_count[i*CNT_W +: CNT_W] = CNT_W'(cnt[i]);
    bus.req_valid = mask;
    val_cyc = cyc;
    for (int k = 0; k < budget && o_done.size() < n; k++) step();
    tmo = (o_done.size() < n);
    for (int k = 0; k < 100 && (cd > 0 || spur_now); k++) step();
    step();
    bus.req_valid = '0;
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    rst = 1'b1;
    repeat (3) step();
    outs = {bus.req_ready, bus.done_pulse, bus.done_abort, bus.grant_id,
            bus.busy, bus.disp_start, bus.jam};
    checks++;
    if (outs !== 14'h0) begin
      errors++; $display("FAIL reset_init outs=%h want 0", outs);
    end
    rst = 1'b0;
    dly = 4; spur_gap = 0; cur_st = 0;
    bus.req_count[0 +: CNT_W] = CNT_W'(3);
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 20 && cur_st < 1; k++) step();
    step(); step();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL reset_midjob_busy got=%b want 1", bus.busy);
    end
    #2 rst = 1'b1;
    #1 outs = {bus.req_ready, bus.done_pulse, bus.done_abort, bus.grant_id,
               bus.busy, bus.disp_start, bus.jam};
    checks++;
    if (outs !== 14'h0) begin
      errors++; $display("FAIL reset_async outs=%h want 0", outs);
    end
    bus.req_valid = '0;
    step(); step();
    rst = 1'b0;
    m_ptr = 0;
    o_done.delete();
    tot_st = 0;
    repeat (12) step();
    checks++;
    if (o_done.size() != 0 || tot_st != 0) begin
      errors++;
      $display("FAIL reset_drop dones=%0d starts=%0d want 0 0", o_done.size(), tot_st);
    end
  endtask

  task automatic test_single();
    int c[NREQ] = '{0, 2, 0, 0};
    bit tmo;
    model_rr(4'b0010, c);
    run_round(4'b0010, c, 4, 0, 200, tmo);
    checks++;
    if (tmo || pk(o_done) != pk(exp_ord)) begin
      errors++; $display("FAIL single_done tmo=%0d got=%h want=%h", tmo, pk(o_done), pk(exp_ord));
    end
    checks++;
    if ((o_rlat.size() > 0 ? o_rlat[0] : -1) != 1) begin
      errors++; $display("FAIL single_ready_lat got=%0d want 1", o_rlat.size() > 0 ? o_rlat[0] : -1);
    end
    checks++;
    if (pk(o_nst) != pk(exp_n)) begin
      errors++; $display("FAIL single_starts got=%h want=%h", pk(o_nst), pk(exp_n));
    end
    checks++;
    if (min_gap < 3 || pk(o_ab) != pk(exp_a)) begin
      errors++; $display("FAIL single_gap_abort gap=%0d ab=%h want>=3 %h", min_gap, pk(o_ab), pk(exp_a));
    end
  endtask

  task automatic test_round_robin();
    int c[NREQ] = '{1, 1, 1, 1};
    bit tmo;
    model_rr(4'b1111, c);
    run_round(4'b1111, c, 3, 0, 400, tmo);
    checks++;
    if (tmo || pk(o_rdy) != pk(exp_ord)) begin
      errors++; $display("FAIL rr_order1 tmo=%0d got=%h want=%h", tmo, pk(o_rdy), pk(exp_ord));
    end
    checks++;
    if (pk(o_done) != pk(exp_ord) || pk(o_nst) != pk(exp_n)) begin
      errors++; $display("FAIL rr_done1 got=%h/%h want=%h/%h", pk(o_done), pk(o_nst), pk(exp_ord), pk(exp_n));
    end
    model_rr(4'b1001, c);
    run_round(4'b1001, c, 2, 0, 400, tmo);
    checks++;
    if (tmo || pk(o_rdy) != pk(exp_ord)) begin
      errors++; $display("FAIL rr_order2 tmo=%0d got=%h want=%h", tmo, pk(o_rdy), pk(exp_ord));
    end
  endtask

  task automatic test_zero_count();
    int c[NREQ] = '{5, 5, 0, 5};
    bit tmo;
    model_rr(4'b0100, c);
    run_round(4'b0100, c, 3, 0, 100, tmo);
    checks++;
    if (tmo || pk(o_done) != pk(exp_ord) || pk(o_nst) != pk(exp_n)) begin
      errors++; $display("FAIL zero_job got=%h/%h want=%h/%h", pk(o_done), pk(o_nst), pk(exp_ord), pk(exp_n));
    end
    checks++;
    if ((o_lat.size() > 0 ? o_lat[0] : -1) != 1) begin
      errors++; $display("FAIL zero_done_lat got=%0d want 1", o_lat.size() > 0 ? o_lat[0] : -1);
    end
  endtask

  task automatic test_spurious();
    int c[NREQ] = '{0, 3, 0, 0};
    bit tmo;
    repeat (3) begin
      spur_now = 1; step();
    end
    step(); step();
    checks++;
    if (bus.busy !== 1'b0 || bus.disp_start !== 1'b0) begin
      errors++; $display("FAIL spur_idle busy=%b start=%b want 0 0", bus.busy, bus.disp_start);
    end
    model_rr(4'b0010, c);
    run_round(4'b0010, c, 2, 1, 200, tmo);
    checks++;
    if (tmo || pk(o_nst) != pk(exp_n) || pk(o_done) != pk(exp_ord)) begin
      errors++; $display("FAIL spur_gap got=%h/%h want=%h/%h", pk(o_done), pk(o_nst), pk(exp_ord), pk(exp_n));
    end
    checks++;
    if (min_gap < 3 || pk(o_ab) != pk(exp_a)) begin
      errors++; $display("FAIL spur_gap_abort gap=%0d ab=%h", min_gap, pk(o_ab));
    end
  endtask

  task automatic test_jam();
    int c[NREQ] = '{1, 0, 0, 1};
    int exp_jam, exp_ab;
    bit tmo;
`ifdef JAM_TIMEOUT_EN
    exp_jam = TMO; exp_ab = 1;
`else
    exp_jam = -1; exp_ab = 0;
`endif
    auto_clr = 1;
    model_rr(4'b1000, c);
    run_round(4'b1000, c, TMO, 0, 300, tmo);
    checks++;
    if ((jam_cyc < 0 ? -1 : jam_cyc - st_cyc) != exp_jam) begin
      errors++; $display("FAIL jam_time got=%0d want=%0d", jam_cyc < 0 ? -1 : jam_cyc - st_cyc, exp_jam);
    end
    checks++;
    if (tmo || pk(o_done) != pk(exp_ord) || (o_ab.size() > 0 ? o_ab[0] : -1) != exp_ab) begin
      errors++; $display("FAIL jam_done tmo=%0d done=%h ab=%0d want %h %0d", tmo, pk(o_done), o_ab.size() > 0 ? o_ab[0] : -1, pk(exp_ord), exp_ab);
    end
    checks++;
    if (bus.jam !== 1'b0 || pk(o_nst) != pk(exp_n) || (exp_jam > 0 && jam_busy != 1)) begin
      errors++; $display("FAIL jam_state jam=%b starts=%h busy_at_jam=%0d", bus.jam, pk(o_nst), jam_busy);
    end
    model_rr(4'b0001, c);
    run_round(4'b0001, c, TMO - 1, 0, 300, tmo);
    checks++;
    if (tmo || jam_cyc != -1 || pk(o_ab) != pk(exp_a)) begin
      errors++; $display("FAIL jam_cmp_wins tmo=%0d jam_cyc=%0d ab=%h want no jam", tmo, jam_cyc, pk(o_ab));
    end
    auto_clr = 0;
    force_clr = 1;
    c = '{0, 0, 2, 0};
    model_rr(4'b0100, c);
    run_round(4'b0100, c, 3, 0, 300, tmo);
    force_clr = 0;
    checks++;
    if (tmo || pk(o_ab) != pk(exp_a) || pk(o_nst) != pk(exp_n)) begin
      errors++; $display("FAIL jam_clr_ignored ab=%h starts=%h want %h %h", pk(o_ab), pk(o_nst), pk(exp_a), pk(exp_n));
    end
    step();
  endtask

  task automatic test_random();
    int c[NREQ];
    logic [NREQ-1:0] m;
    int d;
    bit sg, tmo;
    for (int r = 0; r < 6; r++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      foreach (c[i]) c[i] = $urandom_range(0, 3);
      d = $urandom_range(1, 5);
      sg = 1'($urandom_range(0, 1));
      model_rr(m, c);
      run_round(m, c, d, sg, 600, tmo);
      checks++;
      if (tmo || pk(o_rdy) != pk(exp_ord)) begin
        errors++; $display("FAIL rand%0d_order tmo=%0d got=%h want=%h", r, tmo, pk(o_rdy), pk(exp_ord));
      end
      checks++;
      if (pk(o_done) != pk(exp_ord) || pk(o_nst) != pk(exp_n)) begin
        errors++; $display("FAIL rand%0d_jobs got=%h/%h want=%h/%h", r, pk(o_done), pk(o_nst), pk(exp_ord), pk(exp_n));
      end
      checks++;
      if (pk(o_ab) != pk(exp_a) || min_gap < 3) begin
        errors++; $display("FAIL rand%0d_abort_gap ab=%h gap=%0d", r, pk(o_ab), min_gap);
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL protocol violations=%0d want 0", bad);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_count = '0;
    bus.disp_cmp  = 1'b0;
    bus.jam_clr   = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_count();
    test_spurious();
    test_jam();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
